// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: operand/index words, ALU select and opcode
// encodings, and the execute-stage multiply FSM states.
package cpu_types_pkg;
   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [1:0] {
      ALURT = 2'd0,
      IMM   = 2'd1,
      SHAMT = 2'd2
   } alusrc_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } ex_state_t;
endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and its ALU.
interface alu_if #(parameter int DW = 32);
   import cpu_types_pkg::*;

   logic [DW-1:0] a;
   logic [DW-1:0] b;
   aluop_t        op;
   logic [DW-1:0] result;
   logic          zero;

   modport master (output a, b, op, input result, zero);
   modport slave  (input a, b, op, output result, zero);
endinterface

// File: rtl/ex_stage_fwd_if.sv
// Issue, bypass and result signals of the execute stage.
interface ex_stage_fwd_if #(parameter int DW = 32, parameter int RW = 5);
   logic          en;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_rsdat;
   logic [DW-1:0] in_rtdat;
   logic [DW-1:0] in_imm;
   logic [RW-1:0] in_shamt;
   logic [1:0]    in_alusrc;
   logic [3:0]    in_aluop;
   logic          in_mul;
   logic [RW-1:0] in_rs;
   logic [RW-1:0] in_rt;
   logic [RW-1:0] in_dst;
   logic          in_regwr;
   logic          mem_wr;
   logic          wb_wr;
   logic [RW-1:0] mem_dst;
   logic [RW-1:0] wb_dst;
   logic [DW-1:0] mem_dat;
   logic [DW-1:0] wb_dat;
   logic          ex_valid;
   logic [DW-1:0] ex_result;
   logic [DW-1:0] ex_rtdat;
   logic [RW-1:0] ex_dst;
   logic          ex_regwr;
   logic          ex_zero;
   logic          busy;

   modport master (
      output en, flush, in_valid, in_rsdat, in_rtdat, in_imm, in_shamt,
             in_alusrc, in_aluop, in_mul, in_rs, in_rt, in_dst, in_regwr,
             mem_wr, wb_wr, mem_dst, wb_dst, mem_dat, wb_dat,
      input  ex_valid, ex_result, ex_rtdat, ex_dst, ex_regwr, ex_zero, busy
   );
   modport slave (
      input  en, flush, in_valid, in_rsdat, in_rtdat, in_imm, in_shamt,
             in_alusrc, in_aluop, in_mul, in_rs, in_rt, in_dst, in_regwr,
             mem_wr, wb_wr, mem_dst, wb_dst, mem_dat, wb_dat,
      output ex_valid, ex_result, ex_rtdat, ex_dst, ex_regwr, ex_zero, busy
   );
endinterface

// File: rtl/alu.sv
// Combinational integer ALU; shifts use the low clog2(DW) bits of b.
module alu #(parameter int DW = 32) (
   alu_if.slave aif
);
   import cpu_types_pkg::*;

   localparam int SW = $clog2(DW);

   logic [SW-1:0] sh;
   assign sh = aif.b[SW-1:0];

   always_comb begin
      aif.result = '0;
      case (aif.op)
         ALU_ADD:  aif.result = aif.a + aif.b;
         ALU_SUB:  aif.result = aif.a - aif.b;
         ALU_AND:  aif.result = aif.a & aif.b;
         ALU_OR:   aif.result = aif.a | aif.b;
         ALU_XOR:  aif.result = aif.a ^ aif.b;
         ALU_NOR:  aif.result = ~(aif.a | aif.b);
         ALU_SLT:  aif.result = {{(DW-1){1'b0}}, ($signed(aif.a) < $signed(aif.b))};
         ALU_SLTU: aif.result = {{(DW-1){1'b0}}, (aif.a < aif.b)};
         ALU_SLL:  aif.result = aif.a << sh;
         ALU_SRL:  aif.result = aif.a >> sh;
         ALU_SRA:  aif.result = $signed(aif.a) >>> sh;
         default:  aif.result = '0;
      endcase
   end

   assign aif.zero = (aif.result == '0);
endmodule

// File: rtl/ex_stage_fwd.sv
// Execute stage: ID/EX register, MEM/WB operand bypass, ALU and an
// iterative shift-add multiplier that stalls upstream while it runs.
module ex_stage_fwd #(
   parameter int DW     = 32,
   parameter int RW     = 5,
   parameter int MUL_EN = 1
) (
   input logic           CLK,
   input logic           nRST,
   ex_stage_fwd_if.slave bus
);
   import cpu_types_pkg::*;

   localparam int CW  = $clog2(DW+1);
   localparam bit MEN = (MUL_EN != 0);

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] rsdat;
      logic [DW-1:0] rtdat;
      logic [DW-1:0] imm;
      logic [RW-1:0] shamt;
      alusrc_t       alusrc;
      aluop_t        aluop;
      logic          mul;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] dst;
      logic          regwr;
   } idex_t;

   idex_t         idex;
   logic          mul_ack;
   ex_state_t     state, state_n;
   logic [CW-1:0] cnt, cnt_inc;
   logic [DW-1:0] mcand, mplier, prod;
   logic [DW-1:0] opa, rtf, opb;
   logic          mul_lat, mul_go, mul_done, busy_c, load;

   function automatic logic [DW-1:0] fwd(
      input logic [RW-1:0] idx, input logic [DW-1:0] lat,
      input logic mwr, input logic [RW-1:0] mdst, input logic [DW-1:0] mdat,
      input logic wwr, input logic [RW-1:0] wdst, input logic [DW-1:0] wdat);
      if (idx != '0 && mwr && mdst == idx)      return mdat;
      else if (idx != '0 && wwr && wdst == idx) return wdat;
      else                                      return lat;
   endfunction

   // mul_ack marks a latched multiply whose result has already been shown,
   // so a held instruction is not multiplied a second time.
   assign mul_lat  = MEN && idex.valid && idex.mul;
   assign mul_go   = mul_lat && !mul_ack && (state == IDLE);
   assign mul_done = mul_lat && (state == DONE);
   assign busy_c   = MEN && (mul_go || state == MUL);
   assign load     = bus.en && !busy_c;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idex    <= '0;
         mul_ack <= 1'b0;
      end else if (bus.flush) begin
         idex.valid <= 1'b0;
         idex.regwr <= 1'b0;
         idex.mul   <= 1'b0;
      end else if (load) begin
         idex.valid  <= bus.in_valid;
         idex.rsdat  <= bus.in_rsdat;
         idex.rtdat  <= bus.in_rtdat;
         idex.imm    <= bus.in_imm;
         idex.shamt  <= bus.in_shamt;
         idex.alusrc <= alusrc_t'(bus.in_alusrc);
         idex.aluop  <= aluop_t'(bus.in_aluop);
         idex.mul    <= bus.in_mul && MEN;
         idex.rs     <= bus.in_rs;
         idex.rt     <= bus.in_rt;
         idex.dst    <= bus.in_dst;
         idex.regwr  <= bus.in_regwr;
         mul_ack     <= 1'b0;
      end else if (state == DONE) begin
         mul_ack <= 1'b1;
      end
   end

   assign opa = fwd(idex.rs, idex.rsdat, bus.mem_wr, bus.mem_dst, bus.mem_dat,
                    bus.wb_wr, bus.wb_dst, bus.wb_dat);
   assign rtf = fwd(idex.rt, idex.rtdat, bus.mem_wr, bus.mem_dst, bus.mem_dat,
                    bus.wb_wr, bus.wb_dst, bus.wb_dat);

   always_comb begin
      opb = rtf;
      case (idex.alusrc)
         IMM:     opb = idex.imm;
         SHAMT:   opb = DW'(idex.shamt);
         default: opb = rtf;
      endcase
   end

   alu_if #(.DW(DW)) aif ();
   assign aif.a  = opa;
   assign aif.b  = opb;
   assign aif.op = idex.aluop;

   alu #(.DW(DW)) u_alu (.aif(aif));

   assign cnt_inc = cnt + 1'b1;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (mul_go && !bus.flush) state_n = MUL;
         MUL: begin
            if (bus.flush)                state_n = IDLE;
            else if (cnt_inc == CW'(DW))  state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         cnt    <= '0;
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && state_n == MUL) begin
            mcand  <= opa;
            mplier <= rtf;
            prod   <= '0;
            cnt    <= '0;
         end else if (state == MUL) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt_inc;
         end
      end
   end

   assign bus.busy      = busy_c;
   assign bus.ex_valid  = mul_lat ? mul_done : idex.valid;
   assign bus.ex_result = mul_done ? prod : aif.result;
   assign bus.ex_zero   = nRST && (mul_done ? (prod == '0) : aif.zero);
   assign bus.ex_rtdat  = rtf;
   assign bus.ex_dst    = idex.dst;
   assign bus.ex_regwr  = idex.regwr && bus.ex_valid;
endmodule

// File: tb/tb_ex_stage_fwd.sv
// Scoreboarded bench for the execute stage: ALU/bypass cases, multiply
// latency and result, flush and reset aborts of a running multiply.
module tb_ex_stage_fwd;
   import cpu_types_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   logic CLK  = 1'b0;
   logic nRST = 1'b1;
   always #5 CLK = ~CLK;

   ex_stage_fwd_if #(.DW(DW), .RW(RW)) bus ();
   ex_stage_fwd #(.DW(DW), .RW(RW), .MUL_EN(1)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

   typedef struct {
      logic [DW-1:0] res;
      logic          zero;
   } exp_t;

   exp_t sb[$];
   int total  = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic expect_res(input logic [DW-1:0] res, input logic zero);
      exp_t e;
      e.res  = res;
      e.zero = zero;
      sb.push_back(e);
   endtask

   task automatic outs_zero(input string tag);
      check({tag, "_vld"},   bus.ex_valid,  0);
      check({tag, "_res"},   bus.ex_result, 0);
      check({tag, "_rtd"},   bus.ex_rtdat,  0);
      check({tag, "_dst"},   bus.ex_dst,    0);
      check({tag, "_rwr"},   bus.ex_regwr,  0);
      check({tag, "_zero"},  bus.ex_zero,   0);
      check({tag, "_busy"},  bus.busy,      0);
   endtask

   task automatic clr_byp();
      bus.mem_wr = 0; bus.mem_dst = '0; bus.mem_dat = '0;
      bus.wb_wr  = 0; bus.wb_dst  = '0; bus.wb_dat  = '0;
   endtask

   task automatic issue(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] imm, input logic [RW-1:0] sh,
                        input logic [1:0] src, input logic [3:0] op, input logic mul);
      @(negedge CLK);
      bus.in_valid = 1; bus.in_rs = rs; bus.in_rt = rt;
      bus.in_rsdat = a; bus.in_rtdat = b; bus.in_imm = imm; bus.in_shamt = sh;
      bus.in_alusrc = src; bus.in_aluop = op; bus.in_mul = mul;
      bus.in_dst = 5'd9; bus.in_regwr = 1; bus.en = 1;
      @(posedge CLK); #1;
      bus.en = 0; bus.in_valid = 0;
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      check({tag, "_vld"},  bus.ex_valid, 1);
      check({tag, "_pend"}, (sb.size() > 0), 1);
      if (bus.ex_valid && sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_res"},  bus.ex_result, e.res);
         check({tag, "_zero"}, bus.ex_zero,   e.zero);
         check({tag, "_rwr"},  bus.ex_regwr,  1);
         check({tag, "_dst"},  bus.ex_dst,    9);
      end
   endtask

   task automatic run_mul(input string tag);
      int nb  = 0;
      bit got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (bus.ex_valid) got = 1;
         else begin
            if (bus.busy) nb++;
            @(posedge CLK); #1;
         end
      end
      check({tag, "_done"}, got, 1);
      check({tag, "_busy_cyc"}, nb, DW + 1);
      if (got) begin
         check_out(tag);
         check({tag, "_busy_done"}, bus.busy, 0);
         @(posedge CLK); #1;
         check({tag, "_vld_after"},  bus.ex_valid, 0);
         check({tag, "_busy_after"}, bus.busy, 0);
      end
   endtask

   task automatic watch_quiet(input string tag, input int n);
      int nv = 0;
      int nbz = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge CLK); #1;
         if (bus.ex_valid) nv++;
         if (bus.busy) nbz++;
      end
      check({tag, "_novld"},  nv, 0);
      check({tag, "_nobusy"}, nbz, 0);
   endtask

   initial begin
      bus.en = 0; bus.flush = 0; bus.in_valid = 0;
      bus.in_rsdat = '0; bus.in_rtdat = '0; bus.in_imm = '0; bus.in_shamt = '0;
      bus.in_alusrc = '0; bus.in_aluop = '0; bus.in_mul = 0;
      bus.in_rs = '0; bus.in_rt = '0; bus.in_dst = '0; bus.in_regwr = 0;
      clr_byp();
      #2 nRST = 0;
      #10 outs_zero("reset");
      @(negedge CLK) nRST = 1;

      expect_res(32'd30, 0);
      issue(5'd3, 5'd4, 32'd10, 32'd20, '0, '0, ALURT, ALU_ADD, 0);
      check_out("add");

      bus.mem_wr = 1; bus.mem_dst = 5'd3; bus.mem_dat = 32'd100;
      bus.wb_wr  = 1; bus.wb_dst  = 5'd3; bus.wb_dat  = 32'd7;
      expect_res(32'd120, 0);
      issue(5'd3, 5'd4, 32'd10, 32'd20, '0, '0, ALURT, ALU_ADD, 0);
      check_out("fwd_mem");
      check("fwd_mem_rtd", bus.ex_rtdat, 32'd20);
      clr_byp();

      bus.mem_wr = 1; bus.mem_dst = 5'd0; bus.mem_dat = 32'd55;
      expect_res(32'd30, 0);
      issue(5'd0, 5'd4, 32'd10, 32'd20, '0, '0, ALURT, ALU_ADD, 0);
      check_out("fwd_r0");
      clr_byp();

      bus.wb_wr = 1; bus.wb_dst = 5'd4; bus.wb_dat = 32'd7;
      expect_res(32'd17, 0);
      issue(5'd3, 5'd4, 32'd10, 32'd20, '0, '0, ALURT, ALU_ADD, 0);
      check_out("fwd_wb");
      check("fwd_wb_rtd", bus.ex_rtdat, 32'd7);
      clr_byp();

      expect_res(32'd0, 1);
      issue(5'd3, 5'd4, 32'd20, 32'd20, '0, '0, ALURT, ALU_SUB, 0);
      check_out("sub_zero");

      expect_res(32'd15, 0);
      issue(5'd3, 5'd4, 32'd10, 32'd20, 32'd5, '0, IMM, ALU_ADD, 0);
      check_out("imm");

      expect_res(32'd48, 0);
      issue(5'd3, 5'd4, 32'd3, 32'd20, 32'd99, 5'd4, SHAMT, ALU_SLL, 0);
      check_out("shamt");

      expect_res(32'd30, 0);
      issue(5'd3, 5'd4, 32'd10, 32'd20, 32'd99, 5'd4, 2'd3, ALU_ADD, 0);
      check_out("src3_rt");

      issue(5'd3, 5'd4, 32'd10, 32'd20, '0, '0, ALURT, ALU_ADD, 0);
      @(negedge CLK) bus.flush = 1;
      @(posedge CLK); #1;
      bus.flush = 0;
      check("flush_alu_vld", bus.ex_valid, 0);
      check("flush_alu_rwr", bus.ex_regwr, 0);

      expect_res(32'd42, 0);
      issue(5'd1, 5'd2, 32'd6, 32'd7, '0, '0, ALURT, ALU_ADD, 1);
      check("mul_id_busy", bus.busy, 1);
      check("mul_id_vld", bus.ex_valid, 0);
      run_mul("mul6x7");

      expect_res(32'hFFFF_FFFE, 0);
      issue(5'd1, 5'd2, 32'hFFFF_FFFF, 32'd2, '0, '0, ALURT, ALU_ADD, 1);
      run_mul("mul_wrap");

      expect_res(32'd0, 1);
      issue(5'd1, 5'd2, 32'd0, 32'd9, '0, '0, ALURT, ALU_ADD, 1);
      run_mul("mul_zero");

      issue(5'd1, 5'd2, 32'd6, 32'd7, '0, '0, ALURT, ALU_ADD, 1);
      for (int i = 0; i < 5; i++) begin @(posedge CLK); #1; end
      check("flush_mul_busy_pre", bus.busy, 1);
      bus.flush = 1;
      @(posedge CLK); #1;
      bus.flush = 0;
      check("flush_mul_busy", bus.busy, 0);
      check("flush_mul_vld", bus.ex_valid, 0);
      watch_quiet("flush_mul", 40);

      issue(5'd1, 5'd2, 32'd6, 32'd7, '0, '0, ALURT, ALU_ADD, 1);
      for (int i = 0; i < 10; i++) begin @(posedge CLK); #1; end
      check("rst_mul_busy_pre", bus.busy, 1);
      nRST = 0;
      #1;
      outs_zero("rst_mul");
      check("rst_mul_state", dut.state, IDLE);
      @(negedge CLK) nRST = 1;
      watch_quiet("rst_mul", 40);

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ex_stage_fwd.md
EX_STAGE_FWD -- requirements
Module: ex_stage_fwd

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width in bits.
REQ-002 SHALL have parameter RW, default 5, register-index width.
REQ-003 SHALL have parameter MUL_EN, default 1, 1 enables the iterative multiply unit.
REQ-004 SHALL have ports:
 - CLK  in  1  single clock; all state updates on rising edge.
 - nRST  in  1  asynchronous active-low reset.
 - en  in  1  advance enable; loads the ID/EX register when high.
 - flush  in  1  squash; clears the ID/EX register.
 - in_valid  in  1  issued instruction valid.
 - in_rsdat, in_rtdat, in_imm  in  DW each  register-file and immediate operands.
 - in_shamt  in  RW  shift amount.
 - in_alusrc  in  2  portB select: ALURT, Imm, Shamt.
 - in_aluop  in  4  ALU opcode.
 - in_mul  in  1  instruction is a multiply.
 - in_rs, in_rt, in_dst  in  RW each  source and destination indices.
 - in_regwr  in  1  writes the destination register.
 - mem_wr, wb_wr  in  1 each  MEM/WB stage writes a register.
 - mem_dst, wb_dst  in  RW each  MEM/WB destination.
 - mem_dat, wb_dat  in  DW each  MEM/WB result.
 - ex_valid  out  1  result valid this cycle.
 - ex_result  out  DW  ALU or multiply result.
 - ex_rtdat  out  DW  forwarded rt value for stores.
 - ex_dst  out  RW  destination register.
 - ex_regwr  out  1  destination write enable, gated by ex_valid.
 - ex_zero  out  1  ALU zero flag.
 - busy  out  1  stall request to upstream.

Function
REQ-005 The ID/EX register SHALL load all in_* fields on a rising edge when en=1 and busy=0; otherwise it SHALL hold.
REQ-006 flush SHALL take priority over en and clear the valid, regwr and mul bits of the ID/EX register on the next edge.
REQ-007 Operand A SHALL be forwarded combinationally from the latched rs value; operand rt SHALL be forwarded the same way.
 - Forwarding SHALL apply when the register index is nonzero.
 - Sources SHALL be MEM first, then WB, then the latched value.
 - Match condition: mem_wr and mem_dst equal to the index; wb_wr and wb_dst equal to the index.
REQ-008 Operand B SHALL be the forwarded rt when alusrc=ALURT, latched imm when Imm, and the zero-extended latched shamt when Shamt; any other code SHALL select rt.
REQ-009 A non-multiply instruction SHALL produce its ALU result combinationally in the cycle it occupies the ID/EX register (latency 0 after load).
REQ-010 The multiply FSM SHALL have states IDLE, MUL and DONE:
 - IDLE->MUL on a valid latched in_mul, capturing the forwarded operands.
 - MUL: one shift-add step per cycle for DW cycles, counted by a clog2(DW+1)-bit counter.
 - MUL->DONE when the counter reaches DW.
 - DONE->IDLE after one cycle.
REQ-011 busy SHALL be 1 in the ID/EX cycle of a valid multiply and in every MUL cycle, and 0 in DONE and IDLE.
REQ-012 The multiply result SHALL be the low DW bits of the unsigned product, presented with ex_valid=1 only in DONE.
REQ-013 ex_valid SHALL be 0 for a valid multiply in IDLE and MUL.
REQ-014 flush during MUL SHALL return the FSM to IDLE on the next edge, drop busy, and never assert ex_valid for that multiply.
REQ-015 When MUL_EN=0, in_mul SHALL be ignored and busy SHALL be constant 0.
REQ-016 ex_zero SHALL reflect the ALU zero output; for a multiply in DONE it SHALL be 1 exactly when the product is 0.

Reset
REQ-017 nRST low SHALL asynchronously clear the ID/EX register, FSM (to IDLE), counter and product.
REQ-018 Consequently every output SHALL be 0 during reset, including ex_zero, which is held 0 while reset is asserted.
REQ-019 Reset asserted mid-multiply SHALL abort the multiply with no result produced.

Structure
REQ-020 word_t, regbits_t, alusrc_t (ALURT/Imm/Shamt), aluop_t and ex_state_t SHALL reside in cpu_types_pkg.
REQ-021 The ALU SHALL be instantiated as sub-module alu through alu_if; the multiplier SHALL be internal.

Verification
REQ-022 The bench SHALL cover:
 - ADD rs=3(10), rt=4(20), alusrc=ALURT -> ex_result=30, ex_zero=0, ex_valid=1 same cycle.
 - Same ADD with mem_wr=1, mem_dst=3, mem_dat=100 and wb_wr=1, wb_dst=3, wb_dat=7 -> ex_result=120 (MEM wins).
 - Forward with dst=0, mem_dat=55 -> latched value used, ex_result=30.
 - MUL 6*7, DW=32 -> busy high 33 cycles, DONE with ex_result=42, then busy=0.
 - MUL 0xFFFFFFFF*2 -> ex_result=0xFFFFFFFE.
 - flush at MUL cycle 5 -> next cycle busy=0 and no ex_valid.
 - nRST low at MUL cycle 10 -> all outputs 0, FSM IDLE.
